// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular exponentiation engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SQR,
        ST_SQR_W,
        ST_MUL,
        ST_MUL_W,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int MODE_LEAKY = 0;
    localparam int MODE_CT    = 1;

    // Cycles of a constant-time run: CHECK + DONE plus one full bit slot per exponent bit.
    function automatic int ct_cycles(input int n_w, input int e_w);
        return 2 + e_w * (2 * n_w + 3);
    endfunction

    // Cycles of a leaky run: squares for every significant bit, multiplies only on set bits.
    function automatic int leaky_cycles(input int n_w, input int nb, input int pop);
        return 2 + nb * (n_w + 2) + pop * (n_w + 1);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first shift-add modular multiplier: p = a*b mod n in N_W cycles.
module rsa_modmul #(
    parameter int N_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] a,
    input  logic [N_W-1:0] b,
    input  logic [N_W-1:0] n,
    output logic [N_W-1:0] p,
    output logic           done
);

    localparam int CNT_BITS = $clog2(N_W) + 1;

    logic [N_W-1:0]      a_reg;
    logic [N_W-1:0]      b_reg;
    logic [N_W-1:0]      n_reg;
    logic [N_W-1:0]      acc_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic                run_reg;
    logic                done_reg;

    // One iteration: double modulo n, then add a modulo n when the current bit of b is set.
    // Both operands are below n, so a single conditional subtract suffices after each step.
    function automatic logic [N_W-1:0] mod_step(input logic [N_W-1:0] acc,
                                                 input logic [N_W-1:0] addend,
                                                 input logic [N_W-1:0] modulus,
                                                 input logic           bit_in);
        logic [N_W:0] dbl;
        logic [N_W:0] sum;
        dbl = {acc, 1'b0};
        if (dbl >= {1'b0, modulus}) dbl = dbl - {1'b0, modulus};
        sum = dbl;
        if (bit_in) begin
            sum = dbl + {1'b0, addend};
            if (sum >= {1'b0, modulus}) sum = sum - {1'b0, modulus};
        end
        return sum[N_W-1:0];
    endfunction

    // The start edge already performs the MSB step, so the last step lands in cycle N_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            n_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else if (start) begin
            a_reg    <= a;
            n_reg    <= n;
            b_reg    <= {b[N_W-2:0], 1'b0};
            acc_reg  <= mod_step('0, a, n, b[N_W-1]);
            cnt_reg  <= CNT_BITS'(N_W - 1);
            run_reg  <= 1'b1;
            done_reg <= 1'b0;
        end else if (run_reg) begin
            acc_reg  <= mod_step(acc_reg, a_reg, n_reg, b_reg[N_W-1]);
            b_reg    <= {b_reg[N_W-2:0], 1'b0};
            cnt_reg  <= cnt_reg - 1'b1;
            run_reg  <= (cnt_reg != CNT_BITS'(1));
            done_reg <= (cnt_reg == CNT_BITS'(1));
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign p    = acc_reg;
    assign done = done_reg;

endmodule

// File: rtl/rsa_modexp_ct.sv
// Left-to-right square-and-multiply modular exponentiation with leaky or constant-time schedule.
module rsa_modexp_ct #(
    parameter int N_W        = 16,
    parameter int E_W        = 8,
    parameter int CONST_TIME = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   m,
    input  logic [E_W-1:0]   e,
    input  logic [N_W-1:0]   n,
    output logic [N_W-1:0]   c,
    output logic             finish,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);
    import rsa_pkg::*;

    localparam bit CT_MODE = (CONST_TIME == MODE_CT);
    localparam int IDX_W   = (E_W > 1) ? $clog2(E_W) : 1;

    state_t             state_reg, state_next;
    logic [N_W-1:0]     m_reg, n_reg;
    logic [E_W-1:0]     e_reg;
    logic [N_W-1:0]     r_reg, r_next;
    logic [N_W-1:0]     dummy_reg, dummy_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   msb_idx;
    logic [N_W-1:0]     c_reg, c_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mm_start, mm_done;
    logic [N_W-1:0]     mm_a, mm_b, mm_p;

    rsa_modmul #(.N_W(N_W)) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_reg),
        .p     (mm_p),
        .done  (mm_done)
    );

    // Highest set bit of the captured exponent (leaky schedule starts there).
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < E_W; i++) begin
            if (e_reg[i]) msb_idx = IDX_W'(i);
        end
    end

    // Next-state, datapath updates and multiplier requests.
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        dummy_next = dummy_reg;
        idx_next   = idx_reg;
        c_next     = c_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        mm_start   = 1'b0;
        mm_a       = r_reg;
        mm_b       = r_reg;
        if (state_reg != ST_IDLE && state_reg != ST_DONE && cnt_reg != '1)
            cnt_next = cnt_reg + 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CHECK;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (n_reg < N_W'(2) || m_reg >= n_reg) begin
                    err_next   = 1'b1;
                    c_next     = '0;
                    state_next = ST_DONE;
                end else begin
                    r_next = N_W'(1);
                    if (CT_MODE) begin
                        idx_next   = IDX_W'(E_W - 1);
                        state_next = ST_SQR;
                    end else if (e_reg == '0) begin
                        err_next   = 1'b0;
                        c_next     = N_W'(1);
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = msb_idx;
                        state_next = ST_SQR;
                    end
                end
            end
            ST_SQR: begin
                mm_start   = 1'b1;
                state_next = ST_SQR_W;
            end
            ST_SQR_W: begin
                if (mm_done) begin
                    r_next = mm_p;
                    if (CT_MODE || e_reg[idx_reg]) state_next = ST_MUL;
                    else                           state_next = ST_NEXT;
                end
            end
            ST_MUL: begin
                mm_start   = 1'b1;
                mm_b       = m_reg;
                state_next = ST_MUL_W;
            end
            ST_MUL_W: begin
                if (mm_done) begin
                    if (e_reg[idx_reg]) r_next     = mm_p;
                    else                dummy_next = mm_p;
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_reg == '0) begin
                    c_next     = r_reg;
                    err_next   = 1'b0;
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg - 1'b1;
                    state_next = ST_SQR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; operands are captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            r_reg     <= '0;
            dummy_reg <= '0;
            idx_reg   <= '0;
            c_reg     <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            dummy_reg <= dummy_next;
            idx_reg   <= idx_next;
            c_reg     <= c_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && start) begin
                m_reg <= m;
                e_reg <= e;
                n_reg <= n;
            end
        end
    end

    assign c      = c_reg;
    assign err    = err_reg;
    assign cycles = cnt_reg;
    assign busy   = (state_reg != ST_IDLE);
    assign finish = (state_reg == ST_DONE);

    // A constant-time run must always report the same cycle count (unless it would saturate).
    ct_latency_a: assert property (@(posedge clk) disable iff (rst)
        (CT_MODE && finish && !err &&
         longint'(ct_cycles(N_W, E_W)) < (longint'(1) << CNT_W))
        |-> (longint'(cycles) == longint'(ct_cycles(N_W, E_W))));

endmodule

// File: tb/tb_rsa_modexp_ct.sv
// Scoreboard bench: leaky and constant-time instances run side by side on the same operands.
module tb_rsa_modexp_ct;

    localparam int N_W   = 16;
    localparam int E_W   = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N_W-1:0]   m, n;
    logic [E_W-1:0]   e;
    logic [N_W-1:0]   c_lk, c_ct;
    logic             finish_lk, finish_ct, busy_lk, busy_ct, err_lk, err_ct;
    logic [CNT_W-1:0] cycles_lk, cycles_ct;

    always #5 clk = ~clk;

    rsa_modexp_ct #(.N_W(N_W), .E_W(E_W), .CONST_TIME(0), .CNT_W(CNT_W)) dut_lk (
        .clk(clk), .rst(rst), .start(start), .m(m), .e(e), .n(n),
        .c(c_lk), .finish(finish_lk), .busy(busy_lk), .err(err_lk), .cycles(cycles_lk)
    );

    rsa_modexp_ct #(.N_W(N_W), .E_W(E_W), .CONST_TIME(1), .CNT_W(CNT_W)) dut_ct (
        .clk(clk), .rst(rst), .start(start), .m(m), .e(e), .n(n),
        .c(c_ct), .finish(finish_ct), .busy(busy_ct), .err(err_ct), .cycles(cycles_ct)
    );

    typedef struct {
        int unsigned m, e, n;
        int unsigned c;
        bit          err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q_lk[$];
    exp_t q_ct[$];
    exp_t x_lk, x_ct;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain modular exponentiation over every exponent bit, MSB first.
    function automatic longint model_pow(input longint mi, input longint ei, input longint ni);
        longint r = 1;
        for (int i = E_W - 1; i >= 0; i--) begin
            r = (r * r) % ni;
            if (((ei >> i) & 1) == 1) r = (r * mi) % ni;
        end
        return r;
    endfunction

    // Reference latency from the schedule description.
    function automatic int model_lat(input bit ct, input int unsigned ei, input bit bad);
        int pop = 0;
        int nb  = 0;
        if (bad) return 2;
        if (ct) return 2 + E_W * (2 * N_W + 3);
        for (int i = 0; i < E_W; i++) begin
            if (((ei >> i) & 1) == 1) begin
                pop++;
                nb = i + 1;
            end
        end
        return 2 + nb * (N_W + 2) + pop * (N_W + 1);
    endfunction

    task automatic score(input string tag, input exp_t x, input logic [N_W-1:0] c_a,
                         input logic err_a, input logic [CNT_W-1:0] cyc_a);
        check({tag, "_c"}, c_a, x.c);
        check({tag, "_err"}, err_a, x.err);
        check({tag, "_cycles"}, cyc_a, x.lat);
        check({tag, "_finish_time"}, cyc - x.issue + 1, x.lat);
        $display("txn %s m=%0d e=%0d n=%0d -> c=%0d err=%0d cycles=%0d (exp c=%0d cycles=%0d)",
                 tag, x.m, x.e, x.n, c_a, err_a, cyc_a, x.c, x.lat);
    endtask

    // Monitor for the leaky instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && finish_lk === 1'b1) begin
            check("lk_finish_expected", (q_lk.size() > 0), 1);
            if (q_lk.size() > 0) begin
                x_lk = q_lk.pop_front();
                score("lk", x_lk, c_lk, err_lk, cycles_lk);
            end
        end
    end

    // Monitor for the constant-time instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && finish_ct === 1'b1) begin
            check("ct_finish_expected", (q_ct.size() > 0), 1);
            if (q_ct.size() > 0) begin
                x_ct = q_ct.pop_front();
                score("ct", x_ct, c_ct, err_ct, cycles_ct);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((busy_lk || busy_ct || q_lk.size() != 0 || q_ct.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            check("idle_timeout", k, 0);
            q_lk.delete();
            q_ct.delete();
        end
    endtask

    task automatic issue(input int unsigned mi, input int unsigned ei, input int unsigned ni);
        exp_t x;
        wait_idle();
        @(negedge clk);
        m     = N_W'(mi);
        e     = E_W'(ei);
        n     = N_W'(ni);
        start = 1'b1;
        x.m     = mi;
        x.e     = ei;
        x.n     = ni;
        x.err   = (ni < 2) || (mi >= ni);
        x.c     = x.err ? 0 : int'(model_pow(mi, ei, ni));
        x.issue = cyc + 1;
        x.lat   = model_lat(1'b0, ei, x.err);
        q_lk.push_back(x);
        x.lat   = model_lat(1'b1, ei, x.err);
        q_ct.push_back(x);
        @(negedge clk);
        start = 1'b0;
        m     = N_W'($urandom);
        e     = E_W'($urandom);
        n     = N_W'($urandom);
        check("busy_after_start_lk", busy_lk, 1);
        check("busy_after_start_ct", busy_ct, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rn, rm, re;
        int          f;
        rst   = 1'b1;
        start = 1'b0;
        m     = '0;
        e     = '0;
        n     = '0;
        repeat (3) @(negedge clk);
        check("reset_c_lk", c_lk, 0);
        check("reset_busy_lk", busy_lk, 0);
        check("reset_finish_lk", finish_lk, 0);
        check("reset_err_ct", err_ct, 0);
        check("reset_cycles_ct", cycles_ct, 0);
        check("reset_busy_ct", busy_ct, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan plus operand boundaries.
        issue(89, 3, 3127);
        issue(65, 17, 3233);
        issue(5, 0, 7);
        issue(3127, 3, 3127);
        issue(0, 3, 1);
        issue(1, 255, 2);
        issue(65534, 255, 65535);
        issue(0, 128, 65535);

        // A second start 10 cycles into a run must be ignored.
        issue(89, 3, 3127);
        repeat (9) @(negedge clk);
        m     = N_W'(7);
        e     = E_W'(200);
        n     = N_W'(11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_ignored_start_lk", busy_lk, 1);
        check("busy_during_ignored_start_ct", busy_ct, 1);
        wait_idle();

        // Reset about 50 cycles into a run aborts it without a finish pulse.
        issue(1234, 183, 40001);
        repeat (48) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_c_ct", c_ct, 0);
        check("abort_busy_ct", busy_ct, 0);
        check("abort_finish_ct", finish_ct, 0);
        check("abort_cycles_ct", cycles_ct, 0);
        check("abort_busy_lk", busy_lk, 0);
        rst = 1'b0;
        q_lk.delete();
        q_ct.delete();
        f = 0;
        repeat (400) begin
            @(negedge clk);
            if (finish_lk || finish_ct) f++;
        end
        check("no_finish_after_abort", f, 0);
        issue(65, 17, 3233);

        // Randomised operands, with occasional operand violations.
        for (int i = 0; i < 20; i++) begin
            rn = $urandom_range(65535, 2);
            rm = $urandom_range(rn - 1, 0);
            re = $urandom_range(255, 0);
            if (i % 7 == 3) rm = $urandom_range(65535, rn);
            issue(rm, re, rn);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
